// File: rtl/memshare_rqst_sched_pkg.sv
// memshare_rqst_sched_pkg: scheduler state encoding and pipeline timing constants.
package memshare_rqst_sched_pkg;
  localparam int MEMSHARE_RQSTFLAG_CYCLE = 1;
  localparam int MEMSHARE_REGFILE_RD_CYCLE = 1;
  localparam int MEMSHARE_SKID_PIPE0_CYCLE = 1;
  localparam int MEMSHARE_PIPE_LAT = MEMSHARE_RQSTFLAG_CYCLE + MEMSHARE_REGFILE_RD_CYCLE + MEMSHARE_SKID_PIPE0_CYCLE;
  localparam int MEMSHARE_SCHED_FIFO_DEPTH = 4;
  typedef enum logic [2:0] {CFG, IDLE, ISSUE, WAIT, SEQ} sched_state_e;
endpackage

// File: rtl/memshare_rqst_sched_fifo.sv
// memshare_rqst_sched_fifo: synchronous request FIFO; head is read straight from the storage registers.
module memshare_rqst_sched_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_head = r_mem[r_rd];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/memshare_rqst_sched.sv
// memshare_rqst_sched: loads the L1PA type-0 regFile, then issues buffered request bundles
// one at a time, holding each until the RFMU shift sequence ends (isGtr low).
module memshare_rqst_sched
  import memshare_rqst_sched_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE = 10,
  parameter int RQST_ADDR_BITWIDTH = 4,
  parameter int REGFILE_ADDR_WIDTH = 6,
  parameter int REGFILE_PAGE_WIDTH = 7,
  parameter int REGFILE_PAGE_NUM = 64,
  parameter int FIFO_DEPTH = MEMSHARE_SCHED_FIFO_DEPTH,
  parameter int PIPE_LAT = MEMSHARE_PIPE_LAT,
  parameter int SEQ_SIZE = 4
) (
  input  logic                                         sys_clk,
  input  logic                                         rst,
  input  logic                                         cfg_valid_i,
  output logic                                         cfg_ready_o,
  input  logic [REGFILE_PAGE_WIDTH-1:0]                cfg_wdata_i,
  input  logic                                         cfg_last_i,
  output logic                                         cfg_done_o,
  output logic [REGFILE_ADDR_WIDTH-1:0]                regType0_waddr_o,
  output logic [REGFILE_PAGE_WIDTH-1:0]                regType0_wdata_o,
  output logic                                         regType0_we_o,
  input  logic                                         rqst_valid_i,
  output logic                                         rqst_ready_o,
  input  logic [RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE-1:0] rqst_addr_i,
  output logic                                         issue_valid_o,
  output logic [RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE-1:0] issue_addr_o,
  input  logic                                         isGtr_i,
  output logic                                         inst_done_o,
  output logic [$clog2(SEQ_SIZE):0]                    pat_cnt_o,
  output logic                                         busy_o,
  output logic                                         err_o
);
  localparam int BW = RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE;
  localparam int PW = $clog2(SEQ_SIZE)+1;
  localparam int LW = $clog2(PIPE_LAT)+1;
  localparam logic [REGFILE_ADDR_WIDTH-1:0] LAST_PG = REGFILE_ADDR_WIDTH'(REGFILE_PAGE_NUM-1);
  sched_state_e r_state, w_next;
  logic [REGFILE_ADDR_WIDTH-1:0] r_pg, r_waddr;
  logic [REGFILE_PAGE_WIDTH-1:0] r_wdata;
  logic [LW-1:0] r_lat;
  logic [PW-1:0] r_pat;
  logic [BW-1:0] r_addr, w_head;
  logic r_we, r_cfg_done, r_done, r_err;
  logic w_full, w_empty, w_cfg_hs, w_cfg_end, w_pop, w_fin, w_err;
  memshare_rqst_sched_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(sys_clk),
    .rst(rst),
    .i_push(rqst_valid_i),
    .i_pop(w_pop),
    .i_data(rqst_addr_i),
    .o_head(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign w_cfg_hs = cfg_valid_i && r_state == CFG;
  assign w_cfg_end = w_cfg_hs && (cfg_last_i || r_pg == LAST_PG);
  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= CFG;
    else r_state <= w_next;
  end
  // a sequence ends on isGtr low, or is cut short once SEQ_SIZE patterns are seen with isGtr still high
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    w_fin = 1'b0;
    w_err = 1'b0;
    case (r_state)
      CFG: w_next = w_cfg_end ? IDLE : CFG;
      IDLE: w_next = w_empty ? IDLE : ISSUE;
      ISSUE: begin
        w_pop = 1'b1;
        w_next = PIPE_LAT > 1 ? WAIT : SEQ;
      end
      WAIT: w_next = r_lat <= LW'(1) ? SEQ : WAIT;
      SEQ: begin
        w_err = isGtr_i && r_pat == PW'(SEQ_SIZE-1);
        w_fin = !isGtr_i || w_err;
        w_next = !w_fin ? SEQ : (w_err || w_empty) ? IDLE : ISSUE;
      end
      default: w_next = CFG;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pg <= '0;
      r_we <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cfg_done <= 1'b0;
      r_addr <= '0;
      r_lat <= '0;
      r_pat <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_we <= w_cfg_hs;
      if (w_cfg_hs) begin
        r_waddr <= r_pg;
        r_wdata <= cfg_wdata_i;
      end
      if (w_cfg_hs && r_pg != LAST_PG) r_pg <= r_pg + REGFILE_ADDR_WIDTH'(1);
      if (w_cfg_end) r_cfg_done <= 1'b1;
      if (w_pop) begin
        r_addr <= w_head;
        r_lat <= LW'(PIPE_LAT-1);
      end else if (r_state == WAIT) begin
        r_lat <= r_lat - LW'(1);
      end
      r_pat <= w_pop ? '0 : r_state == SEQ ? r_pat + PW'(1) : r_pat;
      r_done <= w_fin;
      r_err <= r_err | w_err;
    end
  end
  assign cfg_ready_o = r_state == CFG;
  assign cfg_done_o = r_cfg_done;
  assign regType0_we_o = r_we;
  assign regType0_waddr_o = r_waddr;
  assign regType0_wdata_o = r_wdata;
  assign rqst_ready_o = !w_full;
  assign issue_valid_o = r_state == ISSUE;
  assign issue_addr_o = issue_valid_o ? w_head : r_addr;
  assign inst_done_o = r_done;
  assign pat_cnt_o = r_pat;
  assign busy_o = r_state != IDLE && r_state != CFG;
  assign err_o = r_err;
endmodule
